fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the team's synchronous FIFO among NUM_REQ requesters.

---
 rtl/fifo_wr_arbiter_if.sv | 26 ++
 rtl/fifo_wr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester streams plus FIFO write-port signals shared by the write arbiter.
// master = arbiter side, slave = producers/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic [$clog2(DEPTH+1)-1:0]    fifo_count;

  modport master (
    input  req_valid, req_data, req_last, fifo_full, fifo_count,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req_valid, req_data, req_last, fifo_full, fifo_count,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: burst-granular round-robin sharing of one FIFO write port, capped at BURST_MAX beats.
// Optional per-requester statistics are built in when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  fifo_wr_arbiter_if.master            bus,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         locked
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        stat_beats,
  output logic [15:0]                  stat_full_cyc,
  output logic [$clog2(DEPTH+1)-1:0]   stat_peak
`endif
);
  localparam int unsigned IDW  = $clog2(NUM_REQ);
  localparam int unsigned CW   = $clog2(BURST_MAX + 1);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  last_gnt;
  logic [CW-1:0]   beat_cnt;

  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  next_ptr;
  logic            any_valid;
  logic            granted;
  logic            accept;
  logic            burst_end;

  // Rotating-priority search; descending loop so the candidate nearest rr_ptr wins.
  always_comb begin
    winner    = rr_ptr;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % int'(NUM_REQ));
      if (bus.req_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // Grant, zero-latency write path and burst-end detection.
  always_comb begin
    gnt       = (state == S_LOCKED) ? owner : winner;
    granted   = !rst && ((state == S_LOCKED) || any_valid);
    bus.req_ready = '0;
    if (granted && !bus.fifo_full) bus.req_ready[gnt] = 1'b1;
    accept    = granted && !bus.fifo_full && bus.req_valid[gnt];
    bus.fifo_wr_en   = accept;
    bus.fifo_wr_data = bus.req_data[int'(gnt)*int'(DATA_WIDTH) +: DATA_WIDTH];
    burst_end = bus.req_last[gnt] || ((32'(beat_cnt) + 32'd1) == 32'(BURST_MAX));
    next_ptr  = (gnt == IDW'(NUM_REQ - 1)) ? '0 : gnt + IDW'(1);
    if (rst)          grant_id = '0;
    else if (granted) grant_id = gnt;
    else              grant_id = last_gnt;
  end

  assign locked = (state == S_LOCKED);

  // Burst FSM: nothing commits until a beat is actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      last_gnt <= '0;
    end else begin
      if (granted) last_gnt <= gnt;
      if (accept) begin
        if (burst_end) begin
          state    <= S_IDLE;
          rr_ptr   <= next_ptr;
          beat_cnt <= '0;
        end else begin
          state    <= S_LOCKED;
          owner    <= gnt;
          beat_cnt <= beat_cnt + CW'(1);
        end
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating beat/full-stall counters and FIFO occupancy high-water mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_beats    <= '0;
      stat_full_cyc <= '0;
      stat_peak     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (accept && (gnt == IDW'(i)) && (stat_beats[i*16 +: 16] != 16'hFFFF))
          stat_beats[i*16 +: 16] <= stat_beats[i*16 +: 16] + 16'd1;
      end
      if (bus.fifo_full && (|bus.req_valid) && (stat_full_cyc != 16'hFFFF))
        stat_full_cyc <= stat_full_cyc + 16'd1;
      if (bus.fifo_count > stat_peak) stat_peak <= bus.fifo_count;
    end
  end
`else
  logic [CNTW-1:0] unused_count;
  assign unused_count = bus.fifo_count;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus randomized traffic, checked each cycle
// against a burst-level reference model of the round-robin write arbiter.
module tb_fifo_wr_arbiter;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 16;
  localparam int unsigned BURST_MAX  = 4;
  localparam int unsigned IDW        = $clog2(NUM_REQ);
  localparam int unsigned CNTW       = $clog2(DEPTH + 1);
  localparam int unsigned NDW        = NUM_REQ * DATA_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic [IDW-1:0]  grant_id;
  logic            locked;

  fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_beats;
  logic [15:0]           stat_full_cyc;
  logic [CNTW-1:0]       stat_peak;
  int                    s_beats [NUM_REQ];
  int                    s_full;
  int                    s_peak;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .grant_id(grant_id),
    .locked(locked)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_beats(stat_beats),
    .stat_full_cyc(stat_full_cyc),
    .stat_peak(stat_peak)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: the requester currently holding a burst (-1 = none), beats it has
  // sent in this burst, the index to search from next, and the last granted requester.
  int m_own  = -1;
  int m_cnt  = 0;
  int m_prio = 0;
  int m_last = 0;
  int wq[$];
  int n_cmp  = 0;
  int n_bad  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, compare mid-cycle against the model, advance the model at the edge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NDW-1:0] d,
                      input logic [NUM_REQ-1:0] l, input logic f, input logic r,
                      input logic [CNTW-1:0] cnt);
    int g;
    logic [NUM_REQ-1:0] er;
    logic ew;
    bus.req_valid  = v;
    bus.req_data   = d;
    bus.req_last   = l;
    bus.fifo_full  = f;
    bus.fifo_count = cnt;
    rst            = r;
    #3;
    g = -1;
    if (!r) begin
      if (m_own >= 0) g = m_own;
      else
        for (int k = 0; k < int'(NUM_REQ); k++)
          if (g < 0 && v[(m_prio + k) % int'(NUM_REQ)]) g = (m_prio + k) % int'(NUM_REQ);
    end
    er = '0;
    ew = 1'b0;
    if (g >= 0 && !f) begin
      er[g] = 1'b1;
      ew    = v[g];
    end
    check("req_ready", 32'(bus.req_ready), 32'(er));
    check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(ew));
    if (ew) check("fifo_wr_data", 32'(bus.fifo_wr_data), 32'(d[g*int'(DATA_WIDTH) +: DATA_WIDTH]));
    check("grant_id", 32'(grant_id), r ? 32'd0 : (g >= 0 ? 32'(g) : 32'(m_last)));
    check("locked", 32'(locked), 32'(m_own >= 0));
    @(posedge clk);
    #1;
    if (r) begin
      m_own = -1; m_cnt = 0; m_prio = 0; m_last = 0;
`ifdef FIFO_ARB_STATS_EN
      foreach (s_beats[i]) s_beats[i] = 0;
      s_full = 0; s_peak = 0;
`endif
    end else begin
      if (g >= 0) m_last = g;
`ifdef FIFO_ARB_STATS_EN
      if (ew && s_beats[g] < 65535) s_beats[g]++;
      if (f && (|v) && s_full < 65535) s_full++;
      if (int'(cnt) > s_peak) s_peak = int'(cnt);
`endif
      if (ew) begin
        wq.push_back(g);
        m_cnt++;
        if (l[g] || m_cnt == int'(BURST_MAX)) begin
          m_own = -1; m_cnt = 0; m_prio = (g + 1) % int'(NUM_REQ);
        end else m_own = g;
      end
    end
  endtask

  function automatic int count_of(input int id);
    int n = 0;
    foreach (wq[i]) if (wq[i] == id) n++;
    return n;
  endfunction

  logic [NDW-1:0]     rd;
  logic [NUM_REQ-1:0] rl;

  initial begin
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    bus.fifo_full = 1'b0; bus.fifo_count = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then all valid with every beat last: strict 0,1,2,3 rotation.
    wq.delete();
    for (int c = 0; c < 8; c++) step('1, NDW'($urandom), '1, 1'b0, 1'b0, '0);
    check("t1_count", 32'(wq.size()), 32'd8);
    for (int c = 0; c < 8 && c < wq.size(); c++) check("t1_order", 32'(wq[c]), 32'(c % 4));

    // 6-beat burst from req1 split by the cap, req2 slips in between.
    wq.delete();
    for (int c = 0; c < 20 && wq.size() < 7; c++)
      step(4'b0110, NDW'($urandom), (count_of(1) == 5) ? 4'b0110 : 4'b0100, 1'b0, 1'b0, '0);
    check("t2_count", 32'(wq.size()), 32'd7);
    for (int c = 0; c < 7 && c < wq.size(); c++)
      check("t2_order", 32'(wq[c]), (c == 4) ? 32'd2 : 32'd1);

    // Locked req0 stalled by full FIFO for 3 cycles; its next beat beats a valid req3.
    step('0, '0, '0, 1'b0, 1'b1, '0);
    wq.delete();
    step(4'b0001, NDW'($urandom), 4'b0000, 1'b0, 1'b0, '0);
    for (int c = 0; c < 3; c++) step(4'b1001, NDW'($urandom), 4'b0001, 1'b1, 1'b0, '0);
    step(4'b1001, NDW'($urandom), 4'b0001, 1'b0, 1'b0, '0);
    check("t3_count", 32'(wq.size()), 32'd2);
    if (wq.size() == 2) check("t3_beat2", 32'(wq[1]), 32'd0);

    // Reset mid-burst of req2; req0 then wins over req2.
    step(4'b0100, NDW'($urandom), 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0100, NDW'($urandom), 4'b0000, 1'b0, 1'b1, '0);
    wq.delete();
    step(4'b0101, NDW'($urandom), 4'b0101, 1'b0, 1'b0, '0);
    check("t4_count", 32'(wq.size()), 32'd1);
    if (wq.size() == 1) check("t4_winner", 32'(wq[0]), 32'd0);

    // Locked req0 drops valid for 2 cycles; req1 must wait for req0's last beat.
    step('0, '0, '0, 1'b0, 1'b1, '0);
    wq.delete();
    step(4'b0001, NDW'($urandom), 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0010, NDW'($urandom), 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0010, NDW'($urandom), 4'b0000, 1'b0, 1'b0, '0);
    step(4'b0011, NDW'($urandom), 4'b0011, 1'b0, 1'b0, '0);
    step(4'b0010, NDW'($urandom), 4'b0010, 1'b0, 1'b0, '0);
    check("t5_count", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      check("t5_seq1", 32'(wq[1]), 32'd0);
      check("t5_seq2", 32'(wq[2]), 32'd1);
    end

`ifdef FIFO_ARB_STATS_EN
    // 10 beats from req3 around a full period.
    step('0, '0, '0, 1'b0, 1'b1, '0);
    for (int c = 0; c < 16; c++)
      step(4'b1000, NDW'($urandom), 4'b1000, (c >= 5 && c < 11), 1'b0, CNTW'(c));
    check("stat_beats3", 32'(stat_beats[3*16 +: 16]), 32'd10);
    check("stat_beats0", 32'(stat_beats[0 +: 16]), 32'd0);
    check("stat_full_cyc", 32'(stat_full_cyc), 32'd6);
    check("stat_peak", 32'(stat_peak), 32'd15);
`endif

    // Randomized traffic with occasional full stalls and resets.
    for (int c = 0; c < 1500; c++) begin
      rd = NDW'($urandom);
      for (int i = 0; i < int'(NUM_REQ); i++) rl[i] = ($urandom_range(0, 2) == 0);
      step(NUM_REQ'($urandom), rd, rl, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 79) == 0), CNTW'($urandom_range(0, DEPTH)));
    end

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < int'(NUM_REQ); i++)
      check("rand_stat_beats", 32'(stat_beats[i*16 +: 16]), 32'(s_beats[i]));
    check("rand_stat_full", 32'(stat_full_cyc), 32'(s_full));
    check("rand_stat_peak", 32'(stat_peak), 32'(s_peak));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
